freq_chk: RTL and testbench

Receive-side monitor for the divided clocks produced by freq_div (CLK_50 / CLK_10 / CLK_1). It samples one divided clock (SIG_in) in the CLK_in domain and measures the high-phase length, low-phase length and full period in CLK_in cycles. It compares each phase against an expected half-period and reports lock, mismatch and stuck-signal status. It sits alongside the divider as a built-in self-check, and as a frequency meter for externally supplied divided clocks.

---
 rtl/freq_pkg.sv | 26 ++
 rtl/freq_chk_if.sv | 32 +++
 rtl/sync_edge_det.sv | 35 +++
 rtl/freq_chk.sv | 143 ++++++++++++++
 tb/tb_freq_chk.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared definitions for the divided-clock monitor.
//   - state_t    : measurement FSM states
//   - CNT_W_DEF  : default phase counter width
//   - HALF_*     : half-period ratios produced by freq_div (CLK_50/CLK_10/CLK_1)
//   - abs_diff   : unsigned absolute difference without wrap
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEAS_HI = 2'd2,
    MEAS_LO = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 8;

  localparam int HALF_50 = 1;
  localparam int HALF_10 = 5;
  localparam int HALF_1  = 50;

  // Always subtracts the smaller operand from the larger so the result never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/freq_chk_if.sv
// freq_chk_if: control and result bundle of the frequency checker.
//   master : drives EN, SIG_in, EXP_HALF; observes the measurement results
//   slave  : the checker; consumes EN, SIG_in, EXP_HALF; drives HI_LEN, LO_LEN,
//            PERIOD, PERIOD_VLD, LOCK, MISMATCH, STUCK
interface freq_chk_if
  import freq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             EN;
  logic             SIG_in;
  logic [CNT_W-1:0] EXP_HALF;
  logic [CNT_W-1:0] HI_LEN;
  logic [CNT_W-1:0] LO_LEN;
  logic [CNT_W:0]   PERIOD;
  logic             PERIOD_VLD;
  logic             LOCK;
  logic             MISMATCH;
  logic             STUCK;

  modport master (
    output EN, SIG_in, EXP_HALF,
    input  HI_LEN, LO_LEN, PERIOD, PERIOD_VLD, LOCK, MISMATCH, STUCK
  );

  modport slave (
    input  EN, SIG_in, EXP_HALF,
    output HI_LEN, LO_LEN, PERIOD, PERIOD_VLD, LOCK, MISMATCH, STUCK
  );

endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser followed by a one-cycle history flop.
//   clk, rst_n : sampling clock, async active-low reset
//   din        : asynchronous input
//   s          : synchronised level
//   rise, fall : one-cycle edge strobes derived from s and its previous value
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser chain plus history flop; keeps running regardless of the checker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign s    = sync_r[SYNC_STAGES-1];
  assign rise = s & ~prev_r;
  assign fall = ~s & prev_r;

endmodule

// File: rtl/freq_chk.sv
// freq_chk: measures high/low phase lengths and period of a divided clock in
// CLK_in cycles and checks each phase against EXP_HALF +/- TOL.
//   CLK_in, RST_n : measurement clock, async active-low reset
//   bus (slave)   : EN/SIG_in/EXP_HALF in; HI_LEN/LO_LEN/PERIOD/PERIOD_VLD,
//                   LOCK, sticky MISMATCH and STUCK out (all registered)
module freq_chk
  import freq_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic        CLK_in,
  input  logic        RST_n,
  freq_chk_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               RUN_W   = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  logic             s_s, rise_s, fall_s;
  logic             hi_ok_s, lo_ok_s, match_s;
  logic [RUN_W-1:0] run_next_s;

  state_t           state_r;
  logic [CNT_W-1:0] hi_cnt_r, lo_cnt_r, hi_len_r;
  logic [CNT_W-1:0] hi_len_out_r, lo_len_out_r;
  logic [CNT_W:0]   period_r;
  logic             period_vld_r, lock_r, mismatch_r, stuck_r;
  logic [RUN_W-1:0] match_run_r;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (CLK_in),
    .rst_n(RST_n),
    .din  (bus.SIG_in),
    .s    (s_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Tolerance check of the period being closed (latched high phase, running low count).
  always_comb begin
    hi_ok_s    = abs_diff(32'(hi_len_r), 32'(bus.EXP_HALF)) <= TOL;
    lo_ok_s    = abs_diff(32'(lo_cnt_r), 32'(bus.EXP_HALF)) <= TOL;
    match_s    = hi_ok_s & lo_ok_s;
    run_next_s = (match_run_r == RUN_MAX) ? RUN_MAX : match_run_r + {{(RUN_W-1){1'b0}}, 1'b1};
  end

  // Measurement FSM with registered results and status flags.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      state_r      <= IDLE;
      hi_cnt_r     <= {CNT_W{1'b0}};
      lo_cnt_r     <= {CNT_W{1'b0}};
      hi_len_r     <= {CNT_W{1'b0}};
      hi_len_out_r <= {CNT_W{1'b0}};
      lo_len_out_r <= {CNT_W{1'b0}};
      period_r     <= {(CNT_W+1){1'b0}};
      period_vld_r <= 1'b0;
      lock_r       <= 1'b0;
      mismatch_r   <= 1'b0;
      stuck_r      <= 1'b0;
      match_run_r  <= {RUN_W{1'b0}};
    end else begin
      period_vld_r <= 1'b0;
      if (!bus.EN) begin
        // Flags can only be set while enabled, so clearing them for the whole
        // time EN is low is the same as clearing them on the 1->0 transition.
        state_r     <= IDLE;
        lock_r      <= 1'b0;
        match_run_r <= {RUN_W{1'b0}};
        mismatch_r  <= 1'b0;
        stuck_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: state_r <= ALIGN;
          ALIGN: begin
            if (rise_s) begin
              hi_cnt_r <= CNT_ONE;
              state_r  <= MEAS_HI;
            end
          end
          MEAS_HI: begin
            // An edge takes priority over a simultaneous timeout.
            if (fall_s) begin
              hi_len_r <= hi_cnt_r;
              lo_cnt_r <= CNT_ONE;
              state_r  <= MEAS_LO;
            end else if (hi_cnt_r == CNT_MAX) begin
              stuck_r     <= 1'b1;
              lock_r      <= 1'b0;
              match_run_r <= {RUN_W{1'b0}};
              state_r     <= ALIGN;
            end else begin
              hi_cnt_r <= hi_cnt_r + CNT_ONE;
            end
          end
          MEAS_LO: begin
            if (rise_s) begin
              hi_len_out_r <= hi_len_r;
              lo_len_out_r <= lo_cnt_r;
              period_r     <= {1'b0, hi_len_r} + {1'b0, lo_cnt_r};
              period_vld_r <= 1'b1;
              hi_cnt_r     <= CNT_ONE;
              state_r      <= MEAS_HI;
              if (bus.EXP_HALF == {CNT_W{1'b0}}) begin
                lock_r      <= 1'b0;
                match_run_r <= {RUN_W{1'b0}};
              end else if (match_s) begin
                match_run_r <= run_next_s;
                lock_r      <= (run_next_s == RUN_MAX);
              end else begin
                match_run_r <= {RUN_W{1'b0}};
                lock_r      <= 1'b0;
                mismatch_r  <= 1'b1;
              end
            end else if (lo_cnt_r == CNT_MAX) begin
              stuck_r     <= 1'b1;
              lock_r      <= 1'b0;
              match_run_r <= {RUN_W{1'b0}};
              state_r     <= ALIGN;
            end else begin
              lo_cnt_r <= lo_cnt_r + CNT_ONE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bus.HI_LEN     = hi_len_out_r;
  assign bus.LO_LEN     = lo_len_out_r;
  assign bus.PERIOD     = period_r;
  assign bus.PERIOD_VLD = period_vld_r;
  assign bus.LOCK       = lock_r;
  assign bus.MISMATCH   = mismatch_r;
  assign bus.STUCK      = stuck_r;

endmodule

// File: tb/tb_freq_chk.sv
// tb_freq_chk: scoreboard bench for freq_chk. Stimulus pushes the expected
// report of every generated period; a negedge monitor pops on PERIOD_VLD.
// A second instance with TOL=1 shares the stimulus for the tolerance case.
module tb_freq_chk;
  import freq_pkg::*;

  localparam int CNT_W = 8;

  typedef struct {
    int hi;
    int lo;
    int period;
    bit lock;
    bit mm;
    bit stuck;
    int gap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sig = 1'b0;
  logic [CNT_W-1:0] exp_half = '0;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_vld = 0;
  bit   seg_first = 1'b1;

  always #5 clk = ~clk;

  freq_chk_if #(.CNT_W(CNT_W)) bus ();
  freq_chk_if #(.CNT_W(CNT_W)) tol_bus ();

  assign bus.EN           = en;
  assign bus.SIG_in       = sig;
  assign bus.EXP_HALF     = exp_half;
  assign tol_bus.EN       = en;
  assign tol_bus.SIG_in   = sig;
  assign tol_bus.EXP_HALF = exp_half;

  freq_chk #(.SYNC_STAGES(2), .CNT_W(CNT_W), .TOL(0), .LOCK_CNT(4)) u_dut (
    .CLK_in(clk), .RST_n(rst_n), .bus(bus)
  );

  freq_chk #(.SYNC_STAGES(2), .CNT_W(CNT_W), .TOL(1), .LOCK_CNT(4)) u_dut_tol (
    .CLK_in(clk), .RST_n(rst_n), .bus(tol_bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every PERIOD_VLD must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.PERIOD_VLD === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_vld: got PERIOD_VLD=1, expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hi_len",   32'(bus.HI_LEN),   32'(e.hi));
        chk("lo_len",   32'(bus.LO_LEN),   32'(e.lo));
        chk("period",   32'(bus.PERIOD),   32'(e.period));
        chk("lock",     32'(bus.LOCK),     32'(e.lock));
        chk("mismatch", 32'(bus.MISMATCH), 32'(e.mm));
        chk("stuck",    32'(bus.STUCK),    32'(e.stuck));
        if (e.gap != 0) chk("vld_gap", 32'(cyc - last_vld), 32'(e.gap));
      end
      last_vld = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full period of the source: h cycles high, l cycles low.
  task automatic per(input int h, input int l, input bit lk, input bit mm, input bit st);
    exp_t e;
    e.hi = h; e.lo = l; e.period = h + l;
    e.lock = lk; e.mm = mm; e.stuck = st;
    e.gap = seg_first ? 0 : h + l;
    seg_first = 1'b0;
    sb_q.push_back(e);
    sig = 1'b1;
    cycles(h);
    sig = 1'b0;
    cycles(l);
  endtask

  task automatic seg_begin(input int ex);
    exp_half = ex[CNT_W-1:0];
    sig = 1'b0;
    cycles(4);
    en = 1'b1;
    cycles(3);
    seg_first = 1'b1;
  endtask

  // Closing rise: reports the last pushed period.
  task automatic seg_flush();
    sig = 1'b1;
    cycles(5);
  endtask

  task automatic seg_drop();
    en = 1'b0;
    cycles(2);
    chk("drop_lock",     32'(bus.LOCK),     32'd0);
    chk("drop_mismatch", 32'(bus.MISMATCH), 32'd0);
    chk("drop_stuck",    32'(bus.STUCK),    32'd0);
    sig = 1'b0;
    cycles(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cycles(3);
    chk("rst_hi_len", 32'(bus.HI_LEN),     32'd0);
    chk("rst_lo_len", 32'(bus.LO_LEN),     32'd0);
    chk("rst_period", 32'(bus.PERIOD),     32'd0);
    chk("rst_vld",    32'(bus.PERIOD_VLD), 32'd0);
    chk("rst_lock",   32'(bus.LOCK),       32'd0);
    chk("rst_mm",     32'(bus.MISMATCH),   32'd0);
    chk("rst_stuck",  32'(bus.STUCK),      32'd0);
    rst_n = 1'b1;
    cycles(2);

    // CLK_10 lock, then one long high phase and recovery.
    seg_begin(HALF_10);
    for (int i = 0; i < 6; i++) per(5, 5, i >= 3, 1'b0, 1'b0);
    per(6, 5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) per(5, 5, i == 3, 1'b1, 1'b0);
    seg_flush();
    seg_drop();

    // CLK_50 source.
    seg_begin(HALF_50);
    for (int i = 0; i < 5; i++) per(1, 1, i >= 3, 1'b0, 1'b0);
    seg_flush();
    seg_drop();

    // CLK_1 source.
    seg_begin(HALF_1);
    for (int i = 0; i < 2; i++) per(50, 50, 1'b0, 1'b0, 1'b0);
    seg_flush();
    seg_drop();

    // Stuck-high source, then recovery after realignment.
    seg_begin(HALF_10);
    for (int i = 0; i < 4; i++) per(5, 5, i == 3, 1'b0, 1'b0);
    sig = 1'b1;
    cycles(300);
    chk("stuck_flag", 32'(bus.STUCK), 32'd1);
    chk("stuck_lock", 32'(bus.LOCK),  32'd0);
    sig = 1'b0;
    cycles(5);
    seg_first = 1'b1;
    for (int i = 0; i < 2; i++) per(5, 5, 1'b0, 1'b0, 1'b1);
    seg_flush();
    seg_drop();

    // EXP_HALF=6: TOL=1 instance locks, TOL=0 instance mismatches.
    seg_begin(6);
    for (int i = 0; i < 4; i++) per(5, 5, 1'b0, 1'b1, 1'b0);
    seg_flush();
    chk("tol1_lock",     32'(tol_bus.LOCK),     32'd1);
    chk("tol1_mismatch", 32'(tol_bus.MISMATCH), 32'd0);
    chk("tol0_mismatch", 32'(bus.MISMATCH),     32'd1);
    seg_drop();

    // Reset pulse during MEAS_LO.
    seg_begin(HALF_10);
    per(5, 5, 1'b0, 1'b0, 1'b0);
    sig = 1'b1;
    cycles(5);
    sig = 1'b0;
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
    chk("midrst_hi_len", 32'(bus.HI_LEN),     32'd0);
    chk("midrst_period", 32'(bus.PERIOD),     32'd0);
    chk("midrst_vld",    32'(bus.PERIOD_VLD), 32'd0);
    rst_n = 1'b1;
    cycles(3);
    seg_first = 1'b1;
    for (int i = 0; i < 2; i++) per(5, 5, 1'b0, 1'b0, 1'b0);
    seg_flush();
    seg_drop();

    // One-cycle EN drop while locked, during MEAS_LO.
    seg_begin(HALF_10);
    for (int i = 0; i < 4; i++) per(5, 5, i == 3, 1'b0, 1'b0);
    sig = 1'b1;
    cycles(5);
    sig = 1'b0;
    cycles(2);
    en = 1'b0;
    cycles(1);
    en = 1'b1;
    chk("endrop_lock",   32'(bus.LOCK),   32'd0);
    chk("endrop_hi_len", 32'(bus.HI_LEN), 32'd5);
    chk("endrop_period", 32'(bus.PERIOD), 32'd10);
    cycles(3);
    seg_first = 1'b1;
    for (int i = 0; i < 2; i++) per(5, 5, 1'b0, 1'b0, 1'b0);
    seg_flush();
    seg_drop();

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
